// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file geometry and writeback FSM state encoding.
// Imported by the writeback arbiter and its round-robin selector.
package regfile_wb_arbiter_pkg;

   localparam int WORD_LEN          = 32;
   localparam int REG_FILE_ADDR_LEN = 5;
   localparam int REG_FILE_SIZE     = 32;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } wb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin selector: one-hot grant to the first requester after last_grant.
// Purely combinational; the caller owns last_grant.
module rr_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant
);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin among NUM_REQ writers, with an
// optional power-on/software clear sweep enabled by the WB_CLEAR_EN macro.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | sweep writes 0 to registers 1..REG_FILE_SIZE-1, no grants
// ST_RUN   | round-robin arbitration, one registered write per transfer
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   req_valid,
   input  logic [NUM_REQ*REG_FILE_ADDR_LEN-1:0] req_dest,
   input  logic [NUM_REQ*WORD_LEN-1:0]          req_data,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic                                 sw_clear,
   output logic                                 rf_writeEn,
   output logic [REG_FILE_ADDR_LEN-1:0]         rf_dest,
   output logic [WORD_LEN-1:0]                  rf_writeVal,
   output logic                                 busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [REG_FILE_ADDR_LEN-1:0] LAST_IDX = REG_FILE_ADDR_LEN'(REG_FILE_SIZE - 1);

   logic                         arb_en;
   logic [NUM_REQ-1:0]           grant;
   logic [IDX_W-1:0]             last_grant;
   logic                         xfer;
   logic [IDX_W-1:0]             sel_idx;
   logic [REG_FILE_ADDR_LEN-1:0] sel_dest;
   logic [WORD_LEN-1:0]          sel_data;

`ifdef WB_CLEAR_EN
   wb_state_e                    state;
   logic [REG_FILE_ADDR_LEN-1:0] counter;

   // A clear request steals the current cycle so no write races the sweep.
   assign arb_en = (state == ST_RUN) && !sw_clear;
   assign busy   = (state == ST_CLEAR);
`else
   logic unused_sw_clear;

   assign unused_sw_clear = sw_clear;
   assign arb_en          = 1'b1;
   assign busy            = 1'b0;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req        (req_valid & {NUM_REQ{arb_en}}),
      .last_grant (last_grant),
      .grant      (grant)
   );

   assign req_ready = grant;
   assign xfer      = |grant;

   always_comb begin
      sel_idx  = '0;
      sel_dest = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_idx  = IDX_W'(i);
            sel_dest = req_dest[i*REG_FILE_ADDR_LEN +: REG_FILE_ADDR_LEN];
            sel_data = req_data[i*WORD_LEN +: WORD_LEN];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_writeEn  <= 1'b0;
         rf_dest     <= '0;
         rf_writeVal <= '0;
         last_grant  <= IDX_W'(NUM_REQ - 1);
`ifdef WB_CLEAR_EN
         state       <= ST_CLEAR;
         counter     <= REG_FILE_ADDR_LEN'(1);
`endif
      end else begin
`ifdef WB_CLEAR_EN
         if (state == ST_CLEAR) begin
            rf_writeEn  <= 1'b1;
            rf_dest     <= counter;
            rf_writeVal <= '0;
            if (counter == LAST_IDX) begin
               state   <= ST_RUN;
               counter <= REG_FILE_ADDR_LEN'(1);
            end else begin
               counter <= counter + 1'b1;
            end
         end else
`endif
         begin
            // Register 0 is hardwired: accept the transfer but never write it.
            rf_writeEn <= xfer && (sel_dest != '0);
            if (xfer) begin
               last_grant  <= sel_idx;
               rf_dest     <= sel_dest;
               rf_writeVal <= sel_data;
            end
`ifdef WB_CLEAR_EN
            if (sw_clear) begin
               state <= ST_CLEAR;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; covers the clear sweep when
// compiled with WB_CLEAR_EN, otherwise the plain RUN-only build.
module tb_regfile_wb_arbiter;
   import regfile_wb_arbiter_pkg::*;

   localparam int N = 3;
   localparam int A = REG_FILE_ADDR_LEN;
   localparam int W = WORD_LEN;
`ifdef WB_CLEAR_EN
   localparam logic RESET_BUSY = 1'b1;
`else
   localparam logic RESET_BUSY = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*A-1:0] req_dest = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   req_ready;
   logic           sw_clear = 1'b0;
   logic           rf_writeEn;
   logic [A-1:0]   rf_dest;
   logic [W-1:0]   rf_writeVal;
   logic           busy;

   typedef struct {
      int           due;
      logic [A-1:0] dest;
      logic [W-1:0] val;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   regfile_wb_arbiter #(.NUM_REQ(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_dest    (req_dest),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .sw_clear    (sw_clear),
      .rf_writeEn  (rf_writeEn),
      .rf_dest     (rf_dest),
      .rf_writeVal (rf_writeVal),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every register-file write must match the oldest expectation, on its due cycle.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
         checks++;
         errors++;
         $display("FAIL missed_write actual=none expected=dest %0d due %0d (cycle %0d)",
                  sb[0].dest, sb[0].due, cyc);
         void'(sb.pop_front());
      end
      if (rf_writeEn === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=dest %0d val %0h expected=no write (cycle %0d)",
                     rf_dest, rf_writeVal, cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("wb_dest", 64'(rf_dest), 64'(mon_e.dest));
            chk("wb_val", 64'(rf_writeVal), 64'(mon_e.val));
            chk("wb_cycle", 64'(cyc), 64'(mon_e.due));
         end
      end
   end

   task automatic set_req(input int i, input logic v, input logic [A-1:0] d, input logic [W-1:0] x);
      req_valid[i]       = v;
      req_dest[i*A +: A] = d;
      req_data[i*W +: W] = x;
   endtask

   // Called at a negedge with inputs already driven; checks the grant and
   // queues the write the granted requester should produce next cycle.
   task automatic step(input string name, input logic [N-1:0] exp_rdy);
      #1;
      chk(name, 64'(req_ready), 64'(exp_rdy));
      for (int i = 0; i < N; i++) begin
         if (exp_rdy[i] && req_dest[i*A +: A] != '0)
            sb.push_back('{cyc + 1, req_dest[i*A +: A], req_data[i*W +: W]});
      end
      @(negedge clk);
   endtask

`ifdef WB_CLEAR_EN
   task automatic sweep_expect(input int lead, input int last);
      for (int k = 1; k <= last; k++)
         sb.push_back('{cyc + lead + k, A'(k), '0});
   endtask

   task automatic clear_cycles(input int n);
      for (int j = 0; j < n; j++) begin
         #1;
         chk("clear_ready", 64'(req_ready), 64'(0));
         chk("clear_busy", 64'(busy), 64'(1));
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_we", 64'(rf_writeEn), 64'(0));
      chk("rst_dest", 64'(rf_dest), 64'(0));
      chk("rst_val", 64'(rf_writeVal), 64'(0));
      chk("rst_busy", 64'(busy), 64'(RESET_BUSY));
      chk("rst_ready", 64'(req_ready), 64'(0));
      @(negedge clk);

      // First requester after reset: requester 2 alone.
      set_req(2, 1'b1, 5'd9, 32'h99);
      rst = 1'b1;
`ifdef WB_CLEAR_EN
      sweep_expect(0, 31);
      clear_cycles(31);
`endif
      #1 chk("run_busy", 64'(busy), 64'(0));
      step("first_grant", 3'b100);
      set_req(2, 1'b0, '0, '0);

      // All three valid: 0,1,2,0 since requester 0 has priority after 2.
      set_req(0, 1'b1, 5'd5, 32'hA0);
      set_req(1, 1'b1, 5'd6, 32'hA1);
      set_req(2, 1'b1, 5'd7, 32'hA2);
      step("rr_g0", 3'b001);
      step("rr_g1", 3'b010);
      step("rr_g2", 3'b100);
      step("rr_g0b", 3'b001);
      req_valid = '0;
      step("idle", 3'b000);
      #1;
      chk("hold_we", 64'(rf_writeEn), 64'(0));
      chk("hold_dest", 64'(rf_dest), 64'(5));
      chk("hold_val", 64'(rf_writeVal), 64'(32'hA0));
      @(negedge clk);

      // Destination 0 is granted but never written.
      set_req(1, 1'b1, 5'd0, 32'hDEAD);
      step("dest0_ready", 3'b010);
      req_valid = '0;
      #1 chk("dest0_no_we", 64'(rf_writeEn), 64'(0));
      @(negedge clk);

      // Requesters 0 and 2 with last grant 1: 2,0,2.
      set_req(0, 1'b1, 5'd12, 32'hC0);
      set_req(2, 1'b1, 5'd13, 32'hC2);
      step("rot_g2", 3'b100);
      step("rot_g0", 3'b001);
      step("rot_g2b", 3'b100);
      req_valid = '0;
      step("idle2", 3'b000);

`ifdef WB_CLEAR_EN
      // Software clear while requester 2 waits; a second pulse mid-sweep is ignored.
      set_req(2, 1'b1, 5'd17, 32'h1111);
      sw_clear = 1'b1;
      sweep_expect(1, 31);
      step("swclr_block", 3'b000);
      sw_clear = 1'b0;
      clear_cycles(5);
      sw_clear = 1'b1;
      clear_cycles(1);
      sw_clear = 1'b0;
      clear_cycles(25);
      step("swclr_grant", 3'b100);
      req_valid = '0;
      step("idle3", 3'b000);

      // Reset while the sweep is showing dest 10, then a full restart from dest 1.
      sw_clear = 1'b1;
      sweep_expect(1, 10);
      step("swclr2_block", 3'b000);
      sw_clear = 1'b0;
      clear_cycles(10);
      #1 chk("sweep_at10", 64'(rf_dest), 64'(10));
      rst = 1'b0;
      #1;
      chk("sweep_rst_we", 64'(rf_writeEn), 64'(0));
      chk("sweep_rst_dest", 64'(rf_dest), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      sweep_expect(0, 31);
      clear_cycles(31);
      step("restart_idle", 3'b000);
`endif

      // Reset right after a transfer edge drops the in-flight write.
      set_req(0, 1'b1, 5'd3, 32'h33);
      #1 chk("inflight_ready", 64'(req_ready), 64'(3'b001));
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("abort_we", 64'(rf_writeEn), 64'(0));
      chk("abort_dest", 64'(rf_dest), 64'(0));
      chk("abort_val", 64'(rf_writeVal), 64'(0));
      @(negedge clk);
      set_req(0, 1'b0, '0, '0);
      set_req(1, 1'b1, 5'd21, 32'h21);
      set_req(2, 1'b1, 5'd22, 32'h22);
      rst = 1'b1;
`ifdef WB_CLEAR_EN
      sweep_expect(0, 31);
      clear_cycles(31);
`endif
      step("post_rst_prio", 3'b010);
      req_valid = '0;
      repeat (3) @(negedge clk);
      #1 chk("sb_drained", 64'(sb.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of writeback requesters (2..8).
REQ-002 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-005 SHALL have port req_dest  input  NUM_REQ*REG_FILE_ADDR_LEN  packed destination indices, requester i at slice i.
REQ-006 SHALL have port req_data  input  NUM_REQ*WORD_LEN  packed write data, requester i at slice i.
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot-or-zero grant.
REQ-008 SHALL have port sw_clear  input  1  single-cycle pulse requesting a register-file clear sweep.
REQ-009 SHALL have port rf_writeEn  output  1  register-file write enable.
REQ-010 SHALL have port rf_dest  output  REG_FILE_ADDR_LEN  register-file write index.
REQ-011 SHALL have port rf_writeVal  output  WORD_LEN  register-file write data.
REQ-012 SHALL have port busy  output  1  high while in CLEAR.

Function
REQ-013 SHALL implement FSM states CLEAR and RUN.
REQ-014 In RUN, req_ready SHALL be combinational: at most one bit high, selecting the first valid requester in round-robin order starting at (last_grant+1) mod NUM_REQ.
REQ-015 A transfer SHALL occur when req_valid[i] && req_ready[i]; last_grant SHALL update to i on that edge only.
REQ-016 rf_writeEn/rf_dest/rf_writeVal SHALL be registered: a transfer on edge N drives them during cycle N+1, giving a stable value at the intervening negedge write.
REQ-017 A transfer with dest 0 SHALL be accepted but SHALL leave rf_writeEn low.
REQ-018 Without a transfer, rf_writeEn SHALL be 0 in the next cycle; rf_dest/rf_writeVal hold.
REQ-019 In CLEAR, req_ready SHALL be all zero and an index counter SHALL drive rf_writeEn=1, rf_writeVal=0, rf_dest=1..REG_FILE_SIZE-1, one per cycle, in ascending order.
REQ-020 After rf_dest=REG_FILE_SIZE-1 is written, the next cycle SHALL be RUN with busy=0.
REQ-021 sw_clear in RUN SHALL enter CLEAR at the next edge and SHALL block that cycle's grants; sw_clear in CLEAR SHALL be ignored.
REQ-022 Requesters SHALL hold valid, dest and data stable until granted; the arbiter SHALL NOT buffer more than one pending write.

Reset
REQ-023 On rst low: rf_writeEn=0, rf_dest=0, rf_writeVal=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), counter=1.
REQ-024 State after reset SHALL be CLEAR (busy=1) with WB_CLEAR_EN, otherwise RUN (busy=0).
REQ-025 Reset asserted mid-sweep or mid-transfer SHALL abort immediately; a write in flight SHALL be dropped.

Configuration
REQ-026 Macro WB_CLEAR_EN defined: CLEAR state, counter and sw_clear behaviour SHALL be present as above.
REQ-027 WB_CLEAR_EN undefined: FSM SHALL be fixed at RUN, sw_clear SHALL be ignored, busy SHALL tie to 0.

Structure
REQ-028 WORD_LEN, REG_FILE_ADDR_LEN, REG_FILE_SIZE SHALL come from the shared defines; the FSM state enum SHALL live in the shared package.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, last grant; output: one-hot grant).

Verification
REQ-030 WB_CLEAR_EN, release reset -> 31 cycles of writeEn=1, dest 1..31, data 0, then busy=0 (REG_FILE_SIZE=32).
REQ-031 All three valid continuously, dest 5/6/7 -> grants 0,1,2,0 on consecutive cycles; rf_dest 5,6,7,5 one cycle later.
REQ-032 Requester 1 only, dest 0, data 0xDEAD -> ready[1]=1, rf_writeEn stays 0.
REQ-033 sw_clear pulse while requester 2 valid -> ready=0 that cycle, sweep runs, requester 2 granted on first RUN cycle.
REQ-034 rst low during sweep at dest 10 -> outputs zero asynchronously, sweep restarts at dest 1.
REQ-035 WB_CLEAR_EN undefined -> busy=0 from reset, first valid granted in first cycle.
